// File: rtl/serial_mag_comparator.sv
// Bit-serial N-bit magnitude comparator: MSB-first, one bit per clock, early exit.
// Unsigned or two's-complement sense, start/done handshake with sticky result flags.
module serial_mag_comparator #(
    parameter int N      = 8,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         agrb,
    output logic         aeqb,
    output logic         alrb
);

    localparam int   IW     = (N > 2) ? $clog2(N) : 1;
    localparam logic SIGN_B = (SIGNED != 0);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CMP  = 1'b1;

    logic          state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          agrb_q, agrb_d;
    logic          aeqb_q, aeqb_d;
    logic          alrb_q, alrb_d;

    logic msb_stage;
    logic a_wins;

    assign msb_stage = (idx_q == IW'(N-1));
    // On the sign bit a set bit means negative, so the sense flips.
    assign a_wins    = a_q[N-1] ^ (SIGN_B & msb_stage);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        agrb_d  = agrb_q;
        aeqb_d  = aeqb_q;
        alrb_d  = alrb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(N-1);
                    busy_d  = 1'b1;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (a_q[N-1] != b_q[N-1]) begin
                    agrb_d  = a_wins;
                    aeqb_d  = 1'b0;
                    alrb_d  = ~a_wins;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    agrb_d  = 1'b0;
                    aeqb_d  = 1'b1;
                    alrb_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    a_d   = a_q << 1;
                    b_d   = b_q << 1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agrb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            alrb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            agrb_q  <= agrb_d;
            aeqb_q  <= aeqb_d;
            alrb_q  <= alrb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign agrb = agrb_q;
    assign aeqb = aeqb_q;
    assign alrb = alrb_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: N=2 unsigned, N=8 unsigned and N=8 signed.
module tb_serial_mag_comparator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_i [3];
    logic [7:0] a_i     [3];
    logic [7:0] b_i     [3];
    logic       busy_o  [3];
    logic       done_o  [3];
    logic       gt_o    [3];
    logic       eq_o    [3];
    logic       lt_o    [3];

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.N(2), .SIGNED(0)) u_n2 (
        .clk(clk), .reset_n(reset_n), .start(start_i[0]),
        .a(a_i[0][1:0]), .b(b_i[0][1:0]), .busy(busy_o[0]),
        .done(done_o[0]), .agrb(gt_o[0]), .aeqb(eq_o[0]), .alrb(lt_o[0])
    );

    serial_mag_comparator #(.N(8), .SIGNED(0)) u_n8u (
        .clk(clk), .reset_n(reset_n), .start(start_i[1]),
        .a(a_i[1]), .b(b_i[1]), .busy(busy_o[1]),
        .done(done_o[1]), .agrb(gt_o[1]), .aeqb(eq_o[1]), .alrb(lt_o[1])
    );

    serial_mag_comparator #(.N(8), .SIGNED(1)) u_n8s (
        .clk(clk), .reset_n(reset_n), .start(start_i[2]),
        .a(a_i[2]), .b(b_i[2]), .busy(busy_o[2]),
        .done(done_o[2]), .agrb(gt_o[2]), .aeqb(eq_o[2]), .alrb(lt_o[2])
    );

    // Launch one compare, then count edges after T0 until done (0 = timed out).
    task automatic do_cmp(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [2:0] flg, output int bcnt);
        @(negedge clk);
        start_i[sel] = 1'b1;
        a_i[sel]     = av;
        b_i[sel]     = bv;
        @(posedge clk);
        #1;
        start_i[sel] = 1'b0;
        a_i[sel]     = ~av;
        b_i[sel]     = 8'h5A;
        lat  = 0;
        bcnt = 0;
        flg  = 3'b000;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done_o[sel]) begin
                lat = i;
                flg = {gt_o[sel], eq_o[sel], lt_o[sel]};
                break;
            end
            if (busy_o[sel]) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_i[s] = 1'b0;
            a_i[s]     = 8'h00;
            b_i[s]     = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            ncmp++;
            if ({busy_o[s], done_o[s], gt_o[s], eq_o[s], lt_o[s]} !== 5'b0) begin
                nfail++;
                $display("FAIL reset_state inst%0d got %b want 00000", s,
                         {busy_o[s], done_o[s], gt_o[s], eq_o[s], lt_o[s]});
            end
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            ncmp++;
            if ({busy_o[s], done_o[s], gt_o[s], eq_o[s], lt_o[s]} !== 5'b0) begin
                nfail++;
                $display("FAIL idle_no_start inst%0d got %b want 00000", s,
                         {busy_o[s], done_o[s], gt_o[s], eq_o[s], lt_o[s]});
            end
        end
    endtask

    task automatic test_n2_vectors();
        logic [3:0] vec   [7] = '{4'b1100, 4'b0001, 4'b1001, 4'b1010,
                                  4'b1000, 4'b1111, 4'b1101};
        logic [2:0] exp_f [7] = '{3'b100, 3'b001, 3'b100, 3'b010,
                                  3'b100, 3'b010, 3'b100};
        int         exp_l [7] = '{1, 2, 1, 2, 1, 2, 1};
        int         lat;
        int         bcnt;
        logic [2:0] flg;
        for (int v = 0; v < 7; v++) begin
            do_cmp(0, {6'b0, vec[v][3:2]}, {6'b0, vec[v][1:0]}, lat, flg, bcnt);
            ncmp++;
            if (flg !== exp_f[v]) begin
                nfail++;
                $display("FAIL n2_flags vec%0d got %b want %b", v, flg, exp_f[v]);
            end
            ncmp++;
            if (lat !== exp_l[v]) begin
                nfail++;
                $display("FAIL n2_latency vec%0d got %0d want %0d", v, lat, exp_l[v]);
            end
        end
    endtask

    task automatic test_n8_unsigned();
        int         lat;
        int         bcnt;
        logic [2:0] flg;
        do_cmp(1, 8'hC0, 8'h00, lat, flg, bcnt);
        ncmp++;
        if ({lat, flg} !== {32'd1, 3'b100}) begin
            nfail++;
            $display("FAIL u8_c0_00 got lat=%0d flags=%b want lat=1 flags=100", lat, flg);
        end
        do_cmp(1, 8'h55, 8'h55, lat, flg, bcnt);
        ncmp++;
        if ({lat, flg} !== {32'd8, 3'b010}) begin
            nfail++;
            $display("FAIL u8_55_55 got lat=%0d flags=%b want lat=8 flags=010", lat, flg);
        end
        ncmp++;
        if (bcnt !== 7 || busy_o[1] !== 1'b0) begin
            nfail++;
            $display("FAIL u8_busy_span got %0d busy_at_done=%b want 7 and 0",
                     bcnt, busy_o[1]);
        end
    endtask

    task automatic test_n8_signed();
        int         lat;
        int         bcnt;
        logic [2:0] flg;
        do_cmp(2, 8'h80, 8'h01, lat, flg, bcnt);
        ncmp++;
        if ({lat, flg} !== {32'd1, 3'b001}) begin
            nfail++;
            $display("FAIL s8_80_01 got lat=%0d flags=%b want lat=1 flags=001", lat, flg);
        end
        do_cmp(2, 8'hFF, 8'hFE, lat, flg, bcnt);
        ncmp++;
        if ({lat, flg} !== {32'd8, 3'b100}) begin
            nfail++;
            $display("FAIL s8_ff_fe got lat=%0d flags=%b want lat=8 flags=100", lat, flg);
        end
    endtask

    task automatic test_busy_ignore();
        int   ndone = 0;
        int   lat   = 0;
        logic g     = 1'b0;
        @(negedge clk);
        start_i[1] = 1'b1;
        a_i[1]     = 8'h01;
        b_i[1]     = 8'h00;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start_i[1] = 1'b1;
                a_i[1]     = 8'hFF;
            end
            @(posedge clk);
            #1;
            start_i[1] = 1'b0;
            if (done_o[1]) begin
                ndone++;
                if (ndone == 1) begin
                    lat = i;
                    g   = gt_o[1];
                end
            end
        end
        ncmp++;
        if ({lat, g} !== {32'd8, 1'b1}) begin
            nfail++;
            $display("FAIL ignore_start got lat=%0d agrb=%b want lat=8 agrb=1", lat, g);
        end
        ncmp++;
        if (ndone !== 1) begin
            nfail++;
            $display("FAIL single_done got %0d pulses want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start_i[1] = 1'b1;
        a_i[1]     = 8'h01;
        b_i[1]     = 8'h02;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ncmp++;
        if (busy_o[1] !== 1'b1) begin
            nfail++;
            $display("FAIL busy_before_reset got %b want 1", busy_o[1]);
        end
        reset_n = 1'b0;
        #1;
        ncmp++;
        if ({busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]} !== 5'b0) begin
            nfail++;
            $display("FAIL async_reset got %b want 00000",
                     {busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_o[1] || busy_o[1]) seen++;
        end
        ncmp++;
        if (seen !== 0) begin
            nfail++;
            $display("FAIL no_done_after_reset got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start_i[1] = 1'b1;
        a_i[1]     = 8'h80;
        b_i[1]     = 8'h00;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        @(posedge clk);
        #1;
        ncmp++;
        if ({done_o[1], gt_o[1], eq_o[1], lt_o[1]} !== 4'b1100) begin
            nfail++;
            $display("FAIL b2b_first got %b want 1100",
                     {done_o[1], gt_o[1], eq_o[1], lt_o[1]});
        end
        @(negedge clk);
        start_i[1] = 1'b1;
        a_i[1]     = 8'h00;
        b_i[1]     = 8'hFF;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        ncmp++;
        if ({busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]} !== 5'b10100) begin
            nfail++;
            $display("FAIL b2b_accept_hold got %b want 10100",
                     {busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]});
        end
        @(posedge clk);
        #1;
        ncmp++;
        if ({busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]} !== 5'b01001) begin
            nfail++;
            $display("FAIL b2b_second got %b want 01001",
                     {busy_o[1], done_o[1], gt_o[1], eq_o[1], lt_o[1]});
        end
    endtask

    initial begin
        test_reset();
        test_n2_vectors();
        test_n8_unsigned();
        test_n8_signed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
